// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the asynchronous SRAM controller.
// Latency: none (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enumeration, default access wait count, and the
// {ub_n, lb_n} lane-enable patterns with a small decode helper.
package sram_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        REL
    } state_t;

    // Extra SRAM access cycles after setup; legal range 0..7.
    localparam int WAIT_CYCLES_DEF = 1;

    // Lane enables as {ub_n, lb_n}, active-low.
    localparam logic [1:0] LANE_WORD = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b10;
    localparam logic [1:0] LANE_HI   = 2'b01;
    localparam logic [1:0] LANE_OFF  = 2'b11;

    // Word accesses enable both lanes; byte accesses pick the lane by addr[0].
    function automatic logic [1:0] lane_sel(input logic byte_op, input logic a0);
        if (!byte_op) begin
            return LANE_WORD;
        end
        return a0 ? LANE_HI : LANE_LO;
    endfunction

endpackage

// File: rtl/sram_ctl_lane.sv
// Chip-select and byte-lane decode for the two SRAM chips.
// Latency: purely combinational.
// Backpressure: none; follows the registered request and the enable.
//
// Ports: en (access in progress), cs (addr[19]), a0 (addr[0]), byte_op,
//        ram1/ram2 ce_n, ub_n, lb_n (active-low, all high when en=0).
module sram_ctl_lane
    import sram_ctl_pkg::*;
(
    input  logic en,
    input  logic cs,
    input  logic a0,
    input  logic byte_op,
    output logic ram1_ce_n,
    output logic ram1_ub_n,
    output logic ram1_lb_n,
    output logic ram2_ce_n,
    output logic ram2_ub_n,
    output logic ram2_lb_n
);

    logic [1:0] lanes;

    always_comb begin
        lanes     = en ? lane_sel(byte_op, a0) : LANE_OFF;
        ram1_ce_n = ~(en & ~cs);
        ram2_ce_n = ~(en & cs);
        // The deselected chip keeps its lane enables parked high.
        {ram1_ub_n, ram1_lb_n} = cs ? LANE_OFF : lanes;
        {ram2_ub_n, ram2_lb_n} = cs ? lanes : LANE_OFF;
    end

endmodule

// File: rtl/sram_ctl.sv
// Bus-to-asynchronous-SRAM controller for two 16-bit chips with byte lanes.
// Latency: rd/wr sampled in IDLE; ack is seen by the bus 3+WAIT_CYCLES edges later
//          (posted write: 1 edge later when SRAM_CTL_WRBUF_EN is defined).
// Backpressure: strobes are held until ack; REL waits for both strobes low.
//
// Ports: clk, reset (async, active-high); addr[19:0], data_in, rd, wr, byte_op
//        from the bus; data_out, ack to the bus; ram_a, ram_oe_n, ram_we_n shared
//        SRAM controls; ram1_io/ram2_io chip data buses; per-chip ce_n/ub_n/lb_n.
// Option: define SRAM_CTL_WRBUF_EN for posted writes (early ack, background write).
module sram_ctl
    import sram_ctl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        rd,
    input  logic        wr,
    input  logic        byte_op,
    output logic        ack,
    output logic [17:0] ram_a,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    inout  wire  [15:0] ram1_io,
    inout  wire  [15:0] ram2_io,
    output logic        ram1_ce_n,
    output logic        ram1_ub_n,
    output logic        ram1_lb_n,
    output logic        ram2_ce_n,
    output logic        ram2_ub_n,
    output logic        ram2_lb_n
);

    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic        ack_nxt;
    logic        load;
    logic        wr_ok;
    logic [19:0] addr_q;
    logic [15:0] dat_q;
    logic        byte_q;
    logic        io_drv;
    logic        lane_en;
    logic [15:0] wdat;

`ifdef SRAM_CTL_WRBUF_EN
    // After a posted ack the FSM returns straight to IDLE, so the still-held
    // wr strobe must be masked until the requester drops it.
    logic wr_block;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_block <= 1'b0;
        end else if (state == IDLE && wr_ok) begin
            wr_block <= 1'b1;
        end else if (!wr) begin
            wr_block <= 1'b0;
        end
    end

    assign wr_ok = wr & ~wr_block;
`else
    assign wr_ok = wr;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= ack_nxt;
        end
    end

    // Next state, counter and ack. ack is registered, so it is asserted one
    // state after the point where the access is known to be complete.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ok) begin
                    state_nxt = WR_SETUP;
                    load      = 1'b1;
`ifdef SRAM_CTL_WRBUF_EN
                    ack_nxt   = 1'b1;
`endif
                end else if (rd) begin
                    state_nxt = RD_SETUP;
                    load      = 1'b1;
                end
            end
            RD_SETUP: begin
                if (WC == 3'd0) begin
                    state_nxt = RD_DONE;
                end else begin
                    state_nxt = RD_WAIT;
                    cnt_nxt   = WC - 3'd1;
                end
            end
            RD_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RD_DONE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RD_DONE: begin
                state_nxt = REL;
                ack_nxt   = 1'b1;
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = WC;
            end
            WR_PULSE: begin
                if (cnt == 3'd0) begin
                    state_nxt = WR_HOLD;
`ifndef SRAM_CTL_WRBUF_EN
                    ack_nxt   = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            WR_HOLD: begin
`ifdef SRAM_CTL_WRBUF_EN
                state_nxt = IDLE;
`else
                state_nxt = REL;
`endif
            end
            REL: begin
                if (!rd && !wr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 20'd0;
            dat_q    <= 16'd0;
            byte_q   <= 1'b0;
            data_out <= 16'd0;
        end else begin
            if (load) begin
                addr_q <= addr;
                dat_q  <= data_in;
                byte_q <= byte_op;
            end
            if (state == RD_DONE) begin
                data_out <= addr_q[19] ? ram2_io : ram1_io;
            end
        end
    end

    // SRAM controls decoded from the registered state: reset reaches them
    // immediately through the async state flops.
    always_comb begin
        ram_oe_n = ~(state == RD_SETUP || state == RD_WAIT || state == RD_DONE);
        ram_we_n = ~(state == WR_PULSE);
        io_drv   = (state == WR_SETUP || state == WR_PULSE || state == WR_HOLD);
        lane_en  = (state != IDLE) && (state != REL);
    end

    assign ram_a = addr_q[18:1];
    assign wdat  = byte_q ? {dat_q[7:0], dat_q[7:0]} : dat_q;

    // Only the selected chip's bus is driven, and only during the write states.
    assign ram1_io = (io_drv && !addr_q[19]) ? wdat : 16'hzzzz;
    assign ram2_io = (io_drv &&  addr_q[19]) ? wdat : 16'hzzzz;

    sram_ctl_lane u_lane (
        .en        (lane_en),
        .cs        (addr_q[19]),
        .a0        (addr_q[0]),
        .byte_op   (byte_q),
        .ram1_ce_n (ram1_ce_n),
        .ram1_ub_n (ram1_ub_n),
        .ram1_lb_n (ram1_lb_n),
        .ram2_ce_n (ram2_ce_n),
        .ram2_ub_n (ram2_ub_n),
        .ram2_lb_n (ram2_lb_n)
    );

endmodule

// File: tb/tb_sram_ctl.sv
// Self-checking bench for sram_ctl: two behavioural SRAM chips, a bus driver
// task, and a word-level reference memory. Build with SRAM_CTL_WRBUF_EN to
// exercise the posted-write variant.
`timescale 1ns/1ps
module tb_sram_ctl;

    localparam int W      = 2;
    localparam int RD_LAT = 3 + W;
`ifdef SRAM_CTL_WRBUF_EN
    localparam int WR_LAT = 1;
    localparam bit POSTED = 1'b1;
`else
    localparam int WR_LAT = 3 + W;
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd, wr, byte_op;
    logic        ack;
    logic [17:0] ram_a;
    logic        ram_oe_n, ram_we_n;
    wire  [15:0] ram1_io, ram2_io;
    logic        ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n;

    always #5 clk = ~clk;

    sram_ctl #(.WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .rd        (rd),
        .wr        (wr),
        .byte_op   (byte_op),
        .ack       (ack),
        .ram_a     (ram_a),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram1_io   (ram1_io),
        .ram2_io   (ram2_io),
        .ram1_ce_n (ram1_ce_n),
        .ram1_ub_n (ram1_ub_n),
        .ram1_lb_n (ram1_lb_n),
        .ram2_ce_n (ram2_ce_n),
        .ram2_ub_n (ram2_ub_n),
        .ram2_lb_n (ram2_lb_n)
    );

    // ---------------- behavioural SRAM chips + bus monitor ----------------
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem2 [0:262143];

    assign ram1_io = (!ram1_ce_n && !ram_oe_n && ram_we_n) ? mem1[ram_a] : 16'hzzzz;
    assign ram2_io = (!ram2_ce_n && !ram_oe_n && ram_we_n) ? mem2[ram_a] : 16'hzzzz;

    int          overlap_cnt;
    int          wr_pulse_cnt;
    logic [5:0]  wr_strb;
    logic [17:0] wr_a;
    logic [15:0] wr_io;

    initial begin
        overlap_cnt  = 0;
        wr_pulse_cnt = 0;
        wr_strb      = 6'h3f;
        wr_a         = 18'd0;
        wr_io        = 16'd0;
        for (int i = 0; i < 262144; i++) begin
            mem1[i] = 16'd0;
            mem2[i] = 16'd0;
        end
        forever begin
            @(negedge clk);
            if (!ram_oe_n && !ram_we_n) overlap_cnt++;
            if (!ram_we_n) begin
                wr_pulse_cnt++;
                wr_strb = {ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n, ram2_ub_n, ram2_lb_n};
                wr_a    = ram_a;
                wr_io   = ram2_ce_n ? ram1_io : ram2_io;
                if (!ram1_ce_n) begin
                    if (!ram1_lb_n) mem1[ram_a][7:0]  = ram1_io[7:0];
                    if (!ram1_ub_n) mem1[ram_a][15:8] = ram1_io[15:8];
                end
                if (!ram2_ce_n) begin
                    if (!ram2_lb_n) mem2[ram_a][7:0]  = ram2_io[7:0];
                    if (!ram2_ub_n) mem2[ram_a][15:8] = ram2_io[15:8];
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Word memory keyed by {chip, word}; unwritten words read as zero.
    logic [15:0] ref_mem [int];

    function automatic int ref_key(input logic [19:0] a);
        return int'({a[19], a[18:1]});
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        int k;
        k = ref_key(a);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
    endfunction

    task automatic ref_wr(input logic [19:0] a, input logic [15:0] d, input logic b);
        logic [15:0] v;
        v = ref_rd(a);
        if (!b)        v       = d;
        else if (a[0]) v[15:8] = d[7:0];
        else           v[7:0]  = d[7:0];
        ref_mem[ref_key(a)] = v;
    endtask

    // Expected {r1 ce,ub,lb, r2 ce,ub,lb} while the write pulse is active.
    function automatic logic [5:0] exp_strb(input logic [19:0] a, input logic b);
        logic [1:0] ln;
        ln = !b ? 2'b00 : (a[0] ? 2'b01 : 2'b10);
        return a[19] ? {3'b111, 1'b0, ln} : {1'b0, ln, 3'b111};
    endfunction

    // ---------------- bus driver ----------------
    // Called at a negedge. Latency = negedges from strobe assertion until ack
    // is observed, i.e. the edge count at which the bus captures ack.
    task automatic access(input bit is_wr, input bit b, input logic [19:0] a,
                          input logic [15:0] d, input int hold, input int exp_lat,
                          input bit chk_strb, output logic [15:0] rdat);
        int lat;
        int extra;
        int wcnt0;
        int n;
        wcnt0   = wr_pulse_cnt;
        addr    = a;
        data_in = d;
        byte_op = b;
        if (is_wr) begin
            wr = 1'b1;
            ref_wr(a, d, b);
        end else begin
            rd = 1'b1;
        end
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (!POSTED && lat == 1) begin
                // request already sampled: bus-side changes must be ignored
                addr    = 20'($urandom);
                data_in = 16'($urandom);
                byte_op = ~b;
            end
            if (ack) break;
        end
        check("ack_seen", ack, 1);
        rdat = data_out;
        if (exp_lat >= 0) check(is_wr ? "wr_lat" : "rd_lat", lat, exp_lat);
        if (!is_wr) check("rd_data", rdat, ref_rd(a));
        extra = 0;
        for (int i = 0; i < hold + 2; i++) begin
            if (i == hold) begin
                rd = 1'b0;
                wr = 1'b0;
            end
            @(negedge clk);
            if (ack) extra++;
        end
        check("ack_once", extra, 0);
        if (is_wr && chk_strb) begin
            n = 0;
            while (n < 40 && !(wr_pulse_cnt != wcnt0 && ram_we_n)) begin
                @(negedge clk);
                n++;
            end
            check("wr_done", (wr_pulse_cnt != wcnt0 && ram_we_n), 1);
            check("wr_strb", wr_strb, exp_strb(a, b));
            check("wr_addr", wr_a, a[18:1]);
            check("wr_io", wr_io, b ? {d[7:0], d[7:0]} : d);
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] r;
        logic [19:0] a;
        logic [15:0] d;
        bit          iw;
        bit          b;
        int          n;

        reset   = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        byte_op = 1'b0;
        addr    = 20'd0;
        data_in = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dout", data_out, 0);
        check("rst_ctl_n", {ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n,
                            ram2_ce_n, ram2_ub_n, ram2_lb_n}, 8'hff);
        check("rst_ram_a", ram_a, 0);
        reset = 1'b0;

        // word write then read, ram1
        access(1'b1, 1'b0, 20'h00000, 16'ha5a5, 0, WR_LAT, 1'b1, r);
        access(1'b0, 1'b0, 20'h00000, 16'h0000, 0, RD_LAT, 1'b0, r);
        check("word_rd", r, 16'ha5a5);

        // byte write into the upper lane
        access(1'b1, 1'b0, 20'h00004, 16'h1234, 0, WR_LAT, 1'b1, r);
        access(1'b1, 1'b1, 20'h00005, 16'h00ab, 0, WR_LAT, 1'b1, r);
        access(1'b0, 1'b0, 20'h00004, 16'h0000, 0, RD_LAT, 1'b0, r);
        check("byte_rd", r, 16'hab34);
        access(1'b1, 1'b0, 20'h00006, 16'h7777, 0, WR_LAT, 1'b1, r);
        check("dout_hold", r, 16'hab34);

        // chip select isolation
        access(1'b1, 1'b0, 20'h80002, 16'h5a5a, 0, WR_LAT, 1'b1, r);
        access(1'b0, 1'b0, 20'h00002, 16'h0000, 0, RD_LAT, 1'b0, r);
        check("cs_iso", (r != 16'h5a5a), 1);

        // held strobe: no retrigger
        access(1'b0, 1'b0, 20'h80002, 16'h0000, 10, RD_LAT, 1'b0, r);
        check("cs2_rd", r, 16'h5a5a);

        // write immediately followed by read of the same word
        access(1'b1, 1'b0, 20'h00010, 16'hbeef, 0, WR_LAT, 1'b0, r);
        access(1'b0, 1'b0, 20'h00010, 16'h0000, 0, POSTED ? -1 : RD_LAT, 1'b0, r);
        check("b2b_rd", r, 16'hbeef);

        // randomized traffic over a small window of both chips
        for (int i = 0; i < 60; i++) begin
            a      = 20'd0;
            a[19]  = 1'($urandom_range(1, 0));
            a[3:1] = 3'($urandom_range(7, 0));
            a[0]   = 1'($urandom_range(1, 0));
            d      = 16'($urandom);
            iw     = 1'($urandom_range(1, 0));
            b      = 1'($urandom_range(1, 0));
            access(iw, b, a, d, int'($urandom_range(2, 0)),
                   POSTED ? -1 : (iw ? WR_LAT : RD_LAT), 1'b1, r);
        end

        // reset in the middle of a write pulse; that word is never read back
        addr    = 20'h800c8;
        data_in = 16'hdead;
        byte_op = 1'b0;
        wr      = 1'b1;
        n = 0;
        while (n < 20 && ram_we_n) begin
            @(negedge clk);
            n++;
        end
        check("pulse_reached", ram_we_n, 0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we", ram_we_n, 1);
        check("mid_rst_ctl_n", {ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n,
                                ram2_ce_n, ram2_ub_n, ram2_lb_n}, 8'hff);
        check("mid_rst_ack", ack, 0);
        check("mid_rst_dout", data_out, 0);
        check("mid_rst_ram_a", ram_a, 0);
        wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 1'b0, 20'h00006, 16'h0000, 0, RD_LAT, 1'b0, r);

        check("oe_we_overlap", overlap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
